tube_scan: RTL and testbench

//  Memory-mapped 8-digit seven-segment display peripheral on the Nexys4 board.
//  It sits downstream of memorio, next to leds and switchs.
//  CPU stores set a 32-bit hex value, a blank mask and a decimal-point mask.
//  The block time-multiplexes the eight digits with a prescaled scan counter and an anti-ghost blanking gap.

---
 rtl/tube_pkg.sv | 41 ++++
 rtl/tube_scan_if.sv | 31 +++
 rtl/tube_hex_decoder.sv | 14 +
 rtl/tube_scan.sv | 97 +++++++++
 tb/tb_tube_scan.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/tube_pkg.sv
// Shared constants, register layout and hex font for the seven-segment scanner.
package tube_pkg;

  localparam logic [2:0] TUBE_ADDR_LO   = 3'b000;
  localparam logic [2:0] TUBE_ADDR_HI   = 3'b010;
  localparam logic [2:0] TUBE_ADDR_CTRL = 3'b100;

  localparam logic [7:0]  SEG_OFF    = 8'hFF;
  localparam logic [15:0] CTRL_RESET = 16'h00FF;

  // Control register: upper byte lights decimal points, lower byte blanks digits.
  typedef struct packed {
    logic [7:0] dp;
    logic [7:0] blank;
  } tube_ctrl_t;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/tube_scan_if.sv
// CPU-side I/O bus between memorio/control32 and the tube peripheral.
interface tube_scan_if;

  logic        iowrite;
  logic        ioread;
  logic        tubectrl;
  logic [2:0]  address;
  logic [15:0] write_data;
  logic [15:0] ioread_tube;

  // Bus master (CPU side) drives strobes and data, receives readback.
  modport master (
    output iowrite,
    output ioread,
    output tubectrl,
    output address,
    output write_data,
    input  ioread_tube
  );

  // Peripheral side.
  modport slave (
    input  iowrite,
    input  ioread,
    input  tubectrl,
    input  address,
    input  write_data,
    output ioread_tube
  );

endinterface

// File: rtl/tube_hex_decoder.sv
// Combinational 4-to-7 hex decoder for the active-low segment cathodes.
module tube_hex_decoder
  import tube_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure lookup through the shared font.
  always_comb begin
    seg = hex_seg(nibble);
  end

endmodule

// File: rtl/tube_scan.sv
// Memory-mapped 8-digit seven-segment scanner with an anti-ghost blanking gap.
module tube_scan
  import tube_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 23000,
  parameter int unsigned BLANK_CYCLES = 230
) (
  input  logic        clock,
  input  logic        reset,
  tube_scan_if.slave  bus,
  output logic [7:0]  seg_n,
  output logic [7:0]  an_n
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);

  logic [15:0]     data_lo;
  logic [15:0]     data_hi;
  tube_ctrl_t      ctrl;
  logic [DivW-1:0] div_cnt;
  logic [2:0]      dig;
  logic [15:0]     rd_data;
  logic [31:0]     data_all;
  logic [3:0]      cur_nib;
  logic [6:0]      cur_seg;
  logic            slot_dark;
  logic            write_en;

  assign write_en = bus.iowrite & bus.tubectrl;

  // Register file: full 16-bit stores only, unknown addresses dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_lo <= '0;
      data_hi <= '0;
      ctrl    <= CTRL_RESET;
    end else if (write_en) begin
      case (bus.address)
        TUBE_ADDR_LO:   data_lo <= bus.write_data;
        TUBE_ADDR_HI:   data_hi <= bus.write_data;
        TUBE_ADDR_CTRL: ctrl    <= bus.write_data;
        default: ;
      endcase
    end
  end

  // Combinational readback; sees the pre-write value on a simultaneous store.
  always_comb begin
    rd_data = 16'h0000;
    if (bus.ioread && bus.tubectrl) begin
      case (bus.address)
        TUBE_ADDR_LO:   rd_data = data_lo;
        TUBE_ADDR_HI:   rd_data = data_hi;
        TUBE_ADDR_CTRL: rd_data = ctrl;
        default:        rd_data = 16'h0000;
      endcase
    end
  end

  assign bus.ioread_tube = rd_data;

  // Prescaler and digit counter; the digit advances when the prescaler wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
      dig     <= '0;
    end else if (div_cnt == DivW'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      dig     <= dig + 3'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign data_all = {data_hi, data_lo};
  assign cur_nib  = data_all[{dig, 2'b00} +: 4];

  tube_hex_decoder u_hex_decoder (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  // Anodes stay off during the slot's leading gap so the previous digit cannot ghost.
  assign slot_dark = (32'(div_cnt) < BLANK_CYCLES) || ctrl.blank[dig];

  // Registered drive, one cycle behind the counters and registers.
  always_ff @(posedge clock) begin
    if (reset || slot_dark) begin
      an_n  <= SEG_OFF;
      seg_n <= SEG_OFF;
    end else begin
      an_n  <= ~(8'b1 << dig);
      seg_n <= {~ctrl.dp[dig], cur_seg};
    end
  end

endmodule

// File: tb/tb_tube_scan.sv
// Randomized plus directed bench for tube_scan with a time-indexed display model.
module tb_tube_scan;

  localparam int S = 8;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] seg_n;
  logic [7:0] an_n;

  tube_scan_if bus ();

  tube_scan #(
    .SCAN_DIV     (S),
    .BLANK_CYCLES (B)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave),
    .seg_n (seg_n),
    .an_n  (an_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: register contents and cycles elapsed since the reset edge.
  bit          m_valid = 1'b0;
  logic [15:0] m_lo, m_hi, m_ctrl;
  int          m_t;
  logic [15:0] exp_out;

  // Display for a position t cycles into the scan: {an_n, seg_n}.
  function automatic logic [15:0] model_out(int t, logic [15:0] lo, logic [15:0] hi,
                                            logic [15:0] ctl);
    int d, g, nib;
    logic [31:0] all;
    logic [7:0] an;
    d = t % S;
    g = (t / S) % 8;
    if (d < B || ctl[g]) return 16'hFFFF;
    all = {hi, lo};
    nib = int'((all >> (4 * g)) & 32'hF);
    an  = ~(8'h01 << g);
    return {an, ~ctl[8 + g], font[nib]};
  endfunction

  function automatic logic [15:0] model_rd(logic rd, logic cs, logic [2:0] a);
    if (!(rd && cs)) return 16'h0000;
    case (a)
      3'd0: return m_lo;
      3'd2: return m_hi;
      3'd4: return m_ctrl;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %04h expected %04h at %0t", name, act, exp, $time);
  endtask

  // Model update on each edge.
  always @(posedge clk) begin
    if (rst) begin
      m_lo    <= 16'h0000;
      m_hi    <= 16'h0000;
      m_ctrl  <= 16'h00FF;
      m_t     <= 0;
      exp_out <= 16'hFFFF;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      exp_out <= model_out(m_t, m_lo, m_hi, m_ctrl);
      m_t     <= m_t + 1;
      if (bus.iowrite && bus.tubectrl) begin
        case (bus.address)
          3'd0: m_lo   <= bus.write_data;
          3'd2: m_hi   <= bus.write_data;
          3'd4: m_ctrl <= bus.write_data;
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("an_n", {8'h00, an_n}, {8'h00, exp_out[15:8]});
      check("seg_n", {8'h00, seg_n}, {8'h00, exp_out[7:0]});
      check("readback", bus.ioread_tube, model_rd(bus.ioread, bus.tubectrl, bus.address));
      check("one_anode", 16'($countones(~an_n) <= 1), 16'h0001);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.iowrite    = 1'b0;
    bus.ioread     = 1'b0;
    bus.tubectrl   = 1'b0;
    bus.address    = 3'd0;
    bus.write_data = 16'h0000;
  endtask

  task automatic wr(logic [2:0] a, logic [15:0] d, logic cs);
    bus.iowrite    = 1'b1;
    bus.tubectrl   = cs;
    bus.address    = a;
    bus.write_data = d;
    tick();
    idle_bus();
  endtask

  task automatic rd_check(string name, logic [2:0] a, logic [15:0] exp);
    bus.ioread   = 1'b1;
    bus.tubectrl = 1'b1;
    bus.address  = a;
    #1;
    check(name, bus.ioread_tube, exp);
    idle_bus();
  endtask

  // Advance until the outputs show slot position (d, g); lag selects output vs counter view.
  task automatic wait_pos(int d, int g, int lag);
    bit found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (m_t - lag >= 0 && (m_t - lag) % S == d && ((m_t - lag) / S) % 8 == g) found = 1'b1;
    end
    if (!found) check("wait_timeout", 16'h0000, 16'h0001);
  endtask

  initial begin
    idle_bus();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_an", {8'h00, an_n}, 16'h00FF);
    check("reset_seg", {8'h00, seg_n}, 16'h00FF);
    rd_check("reset_rd_lo", 3'd0, 16'h0000);
    rd_check("reset_rd_hi", 3'd2, 16'h0000);
    rd_check("reset_rd_ctrl", 3'd4, 16'h00FF);

    wr(3'd0, 16'h1234, 1'b1);
    wr(3'd2, 16'h5678, 1'b1);
    wr(3'd4, 16'h0000, 1'b1);
    wait_pos(3, 0, 1);
    check("dig0_an", {8'h00, an_n}, 16'h00FE);
    check("dig0_seg", {8'h00, seg_n}, 16'h0099);
    wait_pos(3, 7, 1);
    check("dig7_an", {8'h00, an_n}, 16'h007F);
    check("dig7_seg", {8'h00, seg_n}, 16'h0092);
    wait_pos(2, 0, 1);
    check("wrap_an", {8'h00, an_n}, 16'h00FE);
    wait_pos(0, 1, 1);
    check("gap0_an", {8'h00, an_n}, 16'h00FF);
    tick();
    check("gap1_an", {8'h00, an_n}, 16'h00FF);
    tick();
    check("gap_end_an", {8'h00, an_n}, 16'h00FD);

    wr(3'd4, 16'h0108, 1'b1);
    wait_pos(0, 3, 1);
    for (int i = 0; i < S; i++) begin
      check("blank_dig3", {8'h00, an_n}, 16'h00FF);
      if (i < S - 1) tick();
    end
    wait_pos(4, 0, 1);
    check("dp_dig0_an", {8'h00, an_n}, 16'h00FE);
    check("dp_dig0_seg", {8'h00, seg_n}, 16'h0019);

    wr(3'd6, 16'hFFFF, 1'b1);
    wr(3'd0, 16'hAAAA, 1'b0);
    rd_check("ign_lo", 3'd0, 16'h1234);
    rd_check("ign_hi", 3'd2, 16'h5678);
    rd_check("ign_ctrl", 3'd4, 16'h0108);
    rd_check("ign_addr6", 3'd6, 16'h0000);

    bus.ioread     = 1'b1;
    bus.iowrite    = 1'b1;
    bus.tubectrl   = 1'b1;
    bus.address    = 3'd0;
    bus.write_data = 16'hBEEF;
    #1;
    check("rdw_old", bus.ioread_tube, 16'h1234);
    tick();
    bus.iowrite = 1'b0;
    #1;
    check("rdw_new", bus.ioread_tube, 16'hBEEF);
    idle_bus();

    wait_pos(4, 5, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_an", {8'h00, an_n}, 16'h00FF);
    check("midrst_seg", {8'h00, seg_n}, 16'h00FF);
    rd_check("midrst_ctrl", 3'd4, 16'h00FF);
    wr(3'd4, 16'h0000, 1'b1);
    tick();
    check("restart_gap", {8'h00, an_n}, 16'h00FF);
    tick();
    check("restart_an", {8'h00, an_n}, 16'h00FE);
    check("restart_seg", {8'h00, seg_n}, 16'h00C0);

    for (int i = 0; i < 2500; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      bus.iowrite    = ($urandom_range(0, 3) == 0);
      bus.ioread     = $urandom_range(0, 1) == 1;
      bus.tubectrl   = ($urandom_range(0, 3) != 0);
      bus.address    = 3'($urandom_range(0, 7));
      bus.write_data = 16'($urandom);
      if (bus.address == 3'd4 && $urandom_range(0, 1) == 1) bus.write_data[7:0] = 8'h00;
      tick();
    end
    rst = 1'b0;
    idle_bus();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
